// File: rtl/input_feed_ctrl_pkg.sv
//==============================================================================
// Module   : input_feed_pkg
// Brief    : States, default geometry and helpers for the systolic input feeder.
//            INPUT_FEED_ZERO_FILL_EN adds the ZERO state.
// Revision : 1.0
//==============================================================================
`default_nettype none

package input_feed_pkg;

  localparam int c_def_rows = 4;
  localparam int c_def_cols = 5;
  localparam int c_def_dw   = 16;

`ifdef INPUT_FEED_ZERO_FILL_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ZERO   = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_t;
`endif

  function automatic int last_addr(input int rows, input int cols);
    return rows * cols - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/input_feed_ctrl_if.sv
//==============================================================================
// Module   : input_feed_ctrl_if
// Brief    : Host load stream plus RAM write/read port bundle of the feeder.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface input_feed_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 7
);
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr_in;
  logic          ram_we;
  logic [AW-1:0] ram_addr_out;
  logic          ram_oe;
  logic          feed_valid;
  logic          busy;
  logic          done;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, ram_data, ram_addr_in, ram_we, ram_addr_out,
    input  ram_oe, feed_valid, busy, done
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, ram_data, ram_addr_in, ram_we, ram_addr_out,
    output ram_oe, feed_valid, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/input_feed_ctrl_addr_gen.sv
//==============================================================================
// Module   : feed_addr_gen
// Brief    : Row/col counters and running RAM write address for LOAD and ZERO.
//            INPUT_FEED_ZERO_FILL_EN adds the zero-column walk.
// Revision : 1.0
//==============================================================================
`default_nettype none

module feed_addr_gen
  import input_feed_pkg::*;
#(
  parameter int ROWS = c_def_rows,
  parameter int COLS = c_def_cols,
  parameter int AW   = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
`ifdef INPUT_FEED_ZERO_FILL_EN
  input  logic          zero_mode,
  output logic          zero_last,
`endif
  output logic [AW-1:0] addr,
  output logic          load_last
);

  localparam int c_rw = $clog2(ROWS + 1);
  localparam int c_cw = $clog2(COLS + 1);
`ifdef INPUT_FEED_ZERO_FILL_EN
  localparam int c_col_max = COLS - 2;
`else
  localparam int c_col_max = COLS - 1;
`endif
  localparam logic [c_rw-1:0] c_row_last = c_rw'(ROWS - 1);
  localparam logic [c_cw-1:0] c_col_last = c_cw'(c_col_max);
  // Row wrap jumps over the trailing zero block when the controller owns it
  localparam logic [AW-1:0]   c_row_skip = AW'(COLS - c_col_max);

  logic [c_rw-1:0] r_row;
  logic [c_cw-1:0] r_col;

  assign load_last = (r_row == c_row_last) && (r_col == c_col_last);
`ifdef INPUT_FEED_ZERO_FILL_EN
  assign zero_last = (r_row == c_row_last);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
      addr  <= '0;
    end else if (clear) begin
      r_row <= '0;
      r_col <= '0;
`ifdef INPUT_FEED_ZERO_FILL_EN
      addr  <= zero_mode ? AW'(COLS - 1) : '0;
`else
      addr  <= '0;
`endif
    end else if (advance) begin
`ifdef INPUT_FEED_ZERO_FILL_EN
      if (zero_mode) begin
        r_row <= r_row + c_rw'(1);
        addr  <= addr + AW'(COLS);
      end else
`endif
      if (r_col == c_col_last) begin
        r_col <= '0;
        r_row <= r_row + c_rw'(1);
        addr  <= addr + c_row_skip;
      end else begin
        r_col <= r_col + c_cw'(1);
        addr  <= addr + AW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/input_feed_ctrl.sv
//==============================================================================
// Module   : input_feed_ctrl
// Brief    : Loads host words into the row-skewed systolic input RAM, then
//            sweeps the read column. INPUT_FEED_ZERO_FILL_EN enables ZERO.
// Revision : 1.0
//==============================================================================
`default_nettype none

module input_feed_ctrl
  import input_feed_pkg::*;
#(
  parameter int ROWS = c_def_rows,
  parameter int COLS = c_def_cols,
  parameter int DW   = c_def_dw,
  parameter int AW   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input_feed_ctrl_if.slave  bus
);

  localparam int c_cw = $clog2(COLS + 1);
  localparam logic [c_cw-1:0] c_scol_last = c_cw'(COLS - 1);

  if (AW < $clog2(last_addr(ROWS, COLS) + 1)) begin : g_aw_check
    $error("input_feed_ctrl: AW cannot address ROWS*COLS words");
  end

  state_t          r_state;
  logic [c_cw-1:0] r_scol;
  logic            w_beat;
  logic            w_ag_clear;
  logic            w_ag_adv;
  logic            w_load_last;
  logic [AW-1:0]   w_wr_addr;
`ifdef INPUT_FEED_ZERO_FILL_EN
  logic            w_ag_zero;
  logic            w_zero_last;
`endif

  assign bus.in_ready = (r_state == LOAD);
  assign w_beat       = bus.in_valid && bus.in_ready;

  // The last LOAD beat reloads the generator at the first zero slot
  always_comb begin
    w_ag_clear = (r_state == IDLE);
    w_ag_adv   = w_beat;
`ifdef INPUT_FEED_ZERO_FILL_EN
    w_ag_zero  = 1'b0;
    if (r_state == ZERO) begin
      w_ag_adv  = 1'b1;
      w_ag_zero = 1'b1;
    end
    if (w_beat && w_load_last) begin
      w_ag_clear = 1'b1;
      w_ag_zero  = 1'b1;
    end
`endif
  end

  feed_addr_gen #(
    .ROWS (ROWS),
    .COLS (COLS),
    .AW   (AW)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_ag_clear),
    .advance   (w_ag_adv),
`ifdef INPUT_FEED_ZERO_FILL_EN
    .zero_mode (w_ag_zero),
    .zero_last (w_zero_last),
`endif
    .addr      (w_wr_addr),
    .load_last (w_load_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_scol           <= '0;
      bus.ram_we       <= 1'b0;
      bus.ram_oe       <= 1'b0;
      bus.feed_valid   <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.ram_data     <= {DW{1'b0}};
      bus.ram_addr_in  <= '0;
      bus.ram_addr_out <= '0;
    end else begin
      bus.ram_we     <= 1'b0;
      bus.ram_oe     <= 1'b0;
      bus.feed_valid <= 1'b0;
      bus.done       <= 1'b0;
      case (r_state)
        IDLE: begin
          bus.busy <= bus.start;
          r_scol   <= '0;
          if (bus.start) r_state <= LOAD;
        end
        LOAD: begin
          if (w_beat) begin
            bus.ram_we      <= 1'b1;
            bus.ram_data    <= bus.in_data;
            bus.ram_addr_in <= w_wr_addr;
`ifdef INPUT_FEED_ZERO_FILL_EN
            if (w_load_last) r_state <= ZERO;
`else
            if (w_load_last) r_state <= STREAM;
`endif
          end
        end
`ifdef INPUT_FEED_ZERO_FILL_EN
        ZERO: begin
          bus.ram_we      <= 1'b1;
          bus.ram_data    <= {DW{1'b0}};
          bus.ram_addr_in <= w_wr_addr;
          if (w_zero_last) r_state <= STREAM;
        end
`endif
        STREAM: begin
          bus.ram_oe       <= 1'b1;
          bus.feed_valid   <= 1'b1;
          bus.ram_addr_out <= AW'(r_scol);
          if (r_scol == c_scol_last) begin
            r_scol  <= '0;
            r_state <= DONE;
          end else begin
            r_scol <= r_scol + c_cw'(1);
          end
        end
        DONE: begin
          bus.done <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_input_feed_ctrl.sv
//==============================================================================
// Module   : tb_input_feed_ctrl
// Brief    : Scoreboard bench for input_feed_ctrl (either INPUT_FEED_ZERO_FILL_EN build).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_input_feed_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 5;
  localparam int DW   = 16;
  localparam int AW   = 7;
  localparam int NW   = ROWS * COLS;
`ifdef INPUT_FEED_ZERO_FILL_EN
  localparam int ZF = 1;
`else
  localparam int ZF = 0;
`endif
  localparam int NB       = (ZF != 0) ? ROWS * (COLS - 1) : ROWS * COLS;
  localparam int BASE_LEN = 1 + NB + ((ZF != 0) ? ROWS : 0) + COLS + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  input_feed_ctrl_if #(.DW(DW), .AW(AW)) bus();

  input_feed_ctrl #(
    .ROWS (ROWS),
    .COLS (COLS),
    .DW   (DW),
    .AW   (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            total = 0;
  int            bad   = 0;
  logic [31:0]   wq[$];
  int            sq[$];
  logic [DW-1:0] shadow [NW];
  logic [DW-1:0] exp_img[NW];
  int            last_we_cyc = 0;
  bit            prev_oe = 1'b0;
  logic [31:0]   mon_e;
  int            mon_c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ram_we) begin
        last_we_cyc = cyc;
        if (wq.size() == 0) chk("we_unexpected", wq.size(), 1);
        else begin
          mon_e = wq.pop_front();
          chk("wr_addr", 32'(bus.ram_addr_in), 32'(mon_e[31:16]));
          chk("wr_data", 32'(bus.ram_data), 32'(mon_e[15:0]));
        end
        if (int'(bus.ram_addr_in) < NW) shadow[bus.ram_addr_in] = bus.ram_data;
        chk("we_oe_overlap", 32'(bus.ram_oe), 0);
      end
      if (bus.feed_valid !== bus.ram_oe) chk("fv_vs_oe", 32'(bus.feed_valid), 32'(bus.ram_oe));
      if (bus.ram_oe) begin
        if (!prev_oe) chk("oe_start", cyc, last_we_cyc + 1);
        if (sq.size() == 0) chk("oe_unexpected", sq.size(), 1);
        else begin
          mon_c = sq.pop_front();
          chk("rd_col", 32'(bus.ram_addr_out), mon_c);
          for (int r = 0; r < ROWS; r++)
            chk("q_col", 32'(shadow[r*COLS+mon_c]), 32'(exp_img[r*COLS+mon_c]));
        end
      end
      if (bus.done) chk("done_gap", cyc, last_we_cyc + COLS + 1);
      prev_oe = bus.ram_oe;
    end
  end

  task automatic drive_beat(input int i, input int base);
    int a;
    a = (ZF != 0) ? (i / (COLS - 1)) * COLS + i % (COLS - 1) : i;
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(base + i + 1);
    exp_img[a]   = DW'(base + i + 1);
    wq.push_back({16'(a), 16'(base + i + 1)});
    @(negedge clk);
    chk("rdy", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic run_pass(input bit chained, input bit gaps, input bit noise,
                          input bit chain_next, input int base);
    int n0, idle, oe_seen;
    bit got;
    idle = 0;
    if (!chained) begin
      @(posedge clk); #1;
      bus.start = 1'b1;
      n0 = cyc;
      @(negedge clk);
      chk("busy_pre", 32'(bus.busy), 0);
    end else begin
      n0 = cyc;
    end
    @(posedge clk); #1;
    bus.start = noise;
    for (int i = 0; i < NB; i++) begin
      if (gaps && i > 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        idle++;
      end
      drive_beat(i, base);
    end
    bus.in_valid = 1'b0;
    if (ZF != 0) begin
      for (int r = 0; r < ROWS; r++) begin
        exp_img[r*COLS+COLS-1] = '0;
        wq.push_back({16'(r*COLS+COLS-1), 16'h0000});
      end
    end
    for (int c = 0; c < COLS; c++) sq.push_back(c);
    got = 1'b0;
    oe_seen = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (bus.ram_oe) oe_seen++;
      if (bus.done) begin
        got = 1'b1;
        chk("busy_at_done", 32'(bus.busy), 1);
      end else bus.start = noise && (oe_seen < 2);
    end
    chk("done_seen", 32'(got), 1);
    if (got) chk("done_cycle", cyc - n0, BASE_LEN + idle);
    bus.start = chain_next;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int a = 0; a < NW; a++) begin
      shadow[a]  = '0;
      exp_img[a] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_ram_we", 32'(bus.ram_we), 0);
    chk("rst_ram_oe", 32'(bus.ram_oe), 0);
    chk("rst_feed_valid", 32'(bus.feed_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_ram_data", 32'(bus.ram_data), 0);
    chk("rst_addr_in", 32'(bus.ram_addr_in), 0);
    chk("rst_addr_out", 32'(bus.ram_addr_out), 0);

    // Plain back-to-back load
    run_pass(1'b0, 1'b0, 1'b0, 1'b0, 0);
`ifdef INPUT_FEED_ZERO_FILL_EN
    chk("img_r1c0", 32'(shadow[5]), 32'h0005);
    chk("img_r3c3", 32'(shadow[18]), 32'h0010);
    chk("img_zero9", 32'(shadow[9]), 32'h0000);
`else
    chk("img_r1c0", 32'(shadow[5]), 32'h0006);
    chk("img_last", 32'(shadow[19]), 32'h0014);
`endif
    @(negedge clk);
    chk("busy_after", 32'(bus.busy), 0);

    // in_valid toggling every other cycle
    run_pass(1'b0, 1'b1, 1'b0, 1'b0, 32'h40);

    // start held during LOAD/ZERO/STREAM must not spawn a second pass
    run_pass(1'b0, 1'b0, 1'b1, 1'b0, 32'h80);
    repeat (4) @(negedge clk);
    chk("no_extra_busy", 32'(bus.busy), 0);
    chk("no_extra_ready", 32'(bus.in_ready), 0);

    // Reset mid-LOAD after beat 7
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) drive_beat(i, 32'h100);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
    chk("mid_rst_we", 32'(bus.ram_we), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_addr_in", 32'(bus.ram_addr_in), 0);
    chk("mid_rst_data", 32'(bus.ram_data), 0);
    wq.delete();
    sq.delete();

    // Two passes chained with start held through done
    run_pass(1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
    run_pass(1'b1, 1'b0, 1'b0, 1'b0, 32'h300);
    chk("overwrite_0", 32'(shadow[0]), 32'h0301);

    repeat (3) @(negedge clk);
    chk("wq_empty", wq.size(), 0);
    chk("sq_empty", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
